// File: rtl/eth_pcs_rx_slip_ctrl_if.sv
// Signal bundle between the RX slip sequencer and its gearbox/synchroniser neighbours.
// The slave side is the sequencer; the master side drives the strobes and status.
interface eth_pcs_rx_slip_ctrl_if #(
    parameter int W_SLIP_POS = 7,
    parameter int W_SLIP_CNT = 16
);
    logic                  i_valid;
    logic                  i_slip_req;
    logic                  i_rx_lock;
    logic                  o_sync_valid;
    logic                  o_slip_pulse;
    logic [W_SLIP_POS-1:0] o_slip_pos;
    logic [W_SLIP_CNT-1:0] o_slip_cnt;
    logic                  o_lock_lost;
    logic                  o_timeout;

    modport slave (
        input  i_valid, i_slip_req, i_rx_lock,
        output o_sync_valid, o_slip_pulse, o_slip_pos, o_slip_cnt, o_lock_lost, o_timeout
    );

    modport master (
        output i_valid, i_slip_req, i_rx_lock,
        input  o_sync_valid, o_slip_pulse, o_slip_pos, o_slip_cnt, o_lock_lost, o_timeout
    );
endinterface

// File: rtl/eth_pcs_rx_slip_ctrl.sv
// 10GBASE-R RX bit-slip sequencer: turns synchroniser slip requests into gearbox shifts,
// blanks block-valid while the new boundary settles, and tracks offset, slips, lock loss, timeout.
module eth_pcs_rx_slip_ctrl #(
    parameter int W_SLIP_POS   = 7,
    parameter int SLIP_BLANK   = 4,
    parameter int LOCK_TIMEOUT = 1024,
    parameter int W_SLIP_CNT   = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    eth_pcs_rx_slip_ctrl_if.slave bus
);
    localparam logic [1:0] HUNT   = 2'd0;
    localparam logic [1:0] SLIP   = 2'd1;
    localparam logic [1:0] BLANK  = 2'd2;
    localparam logic [1:0] LOCKED = 2'd3;

    localparam int BLANK_W = (SLIP_BLANK > 1) ? $clog2(SLIP_BLANK) : 1;
    localparam int TMO_W   = $clog2(LOCK_TIMEOUT);

    localparam logic [BLANK_W-1:0]    BLANK_LAST = BLANK_W'(SLIP_BLANK - 1);
    localparam logic [TMO_W-1:0]      TMO_LAST   = TMO_W'(LOCK_TIMEOUT - 1);
    localparam logic [W_SLIP_POS-1:0] POS_LAST   = W_SLIP_POS'(65);

    logic [1:0]            state_q, state_d;
    logic [BLANK_W-1:0]    blank_q, blank_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;
    logic [W_SLIP_POS-1:0] slip_pos_q, slip_pos_d;
    logic [W_SLIP_CNT-1:0] slip_cnt_q, slip_cnt_d;
    logic                  slip_pulse_q, slip_pulse_d;
    logic                  lock_lost_q, lock_lost_d;
    logic                  timeout_q, timeout_d;

    always_comb begin
        state_d     = state_q;
        blank_d     = blank_q;
        tmo_d       = tmo_q;
        slip_pos_d  = slip_pos_q;
        slip_cnt_d  = slip_cnt_q;
        lock_lost_d = 1'b0;
        timeout_d   = 1'b0;

        case (state_q)
            HUNT: begin
                // A slip request outranks lock in the same block.
                if (bus.i_valid && bus.i_slip_req) state_d = SLIP;
                else if (bus.i_rx_lock)            state_d = LOCKED;
            end
            SLIP: begin
                state_d    = BLANK;
                blank_d    = '0;
                slip_pos_d = (slip_pos_q == POS_LAST) ? '0 : slip_pos_q + W_SLIP_POS'(1);
                slip_cnt_d = (slip_cnt_q == '1) ? slip_cnt_q : slip_cnt_q + W_SLIP_CNT'(1);
            end
            BLANK: begin
                if (bus.i_valid) begin
                    if (blank_q == BLANK_LAST) state_d = HUNT;
                    else                       blank_d = blank_q + BLANK_W'(1);
                end
            end
            LOCKED: begin
                if (bus.i_valid && bus.i_slip_req) begin
                    state_d     = SLIP;
                    lock_lost_d = 1'b1;
                end else if (!bus.i_rx_lock) begin
                    state_d     = HUNT;
                    lock_lost_d = 1'b1;
                end
            end
            default: state_d = HUNT;
        endcase

        // Lock-acquisition timer only runs while unlocked; a new lock restarts it.
        if (state_q != LOCKED && bus.i_valid) begin
            if (tmo_q == TMO_LAST) begin
                tmo_d     = '0;
                timeout_d = 1'b1;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end
        if (state_d == LOCKED && state_q != LOCKED) tmo_d = '0;

        slip_pulse_d = (state_d == SLIP);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q      <= HUNT;
            blank_q      <= '0;
            tmo_q        <= '0;
            slip_pos_q   <= '0;
            slip_cnt_q   <= '0;
            slip_pulse_q <= 1'b0;
            lock_lost_q  <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            blank_q      <= blank_d;
            tmo_q        <= tmo_d;
            slip_pos_q   <= slip_pos_d;
            slip_cnt_q   <= slip_cnt_d;
            slip_pulse_q <= slip_pulse_d;
            lock_lost_q  <= lock_lost_d;
            timeout_q    <= timeout_d;
        end
    end

    assign bus.o_sync_valid = bus.i_valid && (state_q == HUNT || state_q == LOCKED);
    assign bus.o_slip_pulse = slip_pulse_q;
    assign bus.o_slip_pos   = slip_pos_q;
    assign bus.o_slip_cnt   = slip_cnt_q;
    assign bus.o_lock_lost  = lock_lost_q;
    assign bus.o_timeout    = timeout_q;
endmodule

// File: tb/tb_eth_pcs_rx_slip_ctrl.sv
// Bench for the RX slip sequencer: one full-width instance plus a 4-bit-counter instance on the
// same stimulus; accepted slips are queued as expectations and retired by a pulse monitor.
module tb_eth_pcs_rx_slip_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    logic valid, slip_req, rx_lock;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    eth_pcs_rx_slip_ctrl_if #(.W_SLIP_POS(7), .W_SLIP_CNT(16)) bus  ();
    eth_pcs_rx_slip_ctrl_if #(.W_SLIP_POS(7), .W_SLIP_CNT(4))  bus4 ();

    assign bus.i_valid     = valid;
    assign bus.i_slip_req  = slip_req;
    assign bus.i_rx_lock   = rx_lock;
    assign bus4.i_valid    = valid;
    assign bus4.i_slip_req = slip_req;
    assign bus4.i_rx_lock  = rx_lock;

    eth_pcs_rx_slip_ctrl #(.W_SLIP_POS(7), .SLIP_BLANK(4), .LOCK_TIMEOUT(8), .W_SLIP_CNT(16)) dut (
        .i_clk(clk), .i_reset_n(rst_n), .bus(bus));
    eth_pcs_rx_slip_ctrl #(.W_SLIP_POS(7), .SLIP_BLANK(4), .LOCK_TIMEOUT(8), .W_SLIP_CNT(4)) dut4 (
        .i_clk(clk), .i_reset_n(rst_n), .bus(bus4));

    typedef struct {
        int          cyc;
        logic [6:0]  pos;
        logic [15:0] cnt;
        logic [3:0]  cnt4;
        logic        lost;
    } exp_t;

    exp_t        sb[$];
    exp_t        pe;
    logic        pend = 1'b0;
    logic [6:0]  exp_pos;
    logic [15:0] exp_cnt;
    logic [3:0]  exp_cnt4;

    // Slip monitor: every pulse must match the head expectation for this cycle; offset and
    // counters are checked one cycle later when the registered update becomes visible.
    always @(negedge clk) begin
        if (!rst_n) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                total++;
                if (bus.o_slip_pos !== pe.pos || bus.o_slip_cnt !== pe.cnt || bus4.o_slip_cnt !== pe.cnt4) begin
                    bad++;
                    $display("FAIL slip_update cyc=%0d got pos=%0d cnt=%0d cnt4=%0d want pos=%0d cnt=%0d cnt4=%0d",
                             cyc, bus.o_slip_pos, bus.o_slip_cnt, bus4.o_slip_cnt, pe.pos, pe.cnt, pe.cnt4);
                end
                pend = 1'b0;
            end
            if (bus.o_slip_pulse) begin
                total++;
                if (sb.size() == 0 || sb[0].cyc != cyc) begin
                    bad++;
                    $display("FAIL slip_unexpected cyc=%0d got pulse=1 want pulse=0", cyc);
                end else begin
                    pe = sb.pop_front();
                    pend = 1'b1;
                    if (bus.o_lock_lost !== pe.lost || bus4.o_slip_pulse !== 1'b1) begin
                        bad++;
                        $display("FAIL slip_lost cyc=%0d got lost=%b pulse4=%b want lost=%b pulse4=1",
                                 cyc, bus.o_lock_lost, bus4.o_slip_pulse, pe.lost);
                    end
                end
            end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
                total++;
                bad++;
                $display("FAIL slip_missing cyc=%0d got pulse=0 want pulse=1", cyc);
                void'(sb.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n    = 1'b0;
        valid    = 1'b0;
        slip_req = 1'b0;
        rx_lock  = 1'b0;
        sb.delete();
        exp_pos  = '0;
        exp_cnt  = '0;
        exp_cnt4 = '0;
        tick();
        tick();
        #2 rst_n = 1'b1;
        tick();
    endtask

    // Drives one slip request in the current cycle and queues the expected result.
    task automatic slip(input logic lost);
        exp_t e;
        slip_req = 1'b1;
        exp_pos  = (exp_pos == 7'd65) ? 7'd0 : exp_pos + 7'd1;
        exp_cnt  = exp_cnt + 16'd1;
        exp_cnt4 = (exp_cnt4 == 4'hf) ? 4'hf : exp_cnt4 + 4'd1;
        e.cyc  = cyc + 1;
        e.pos  = exp_pos;
        e.cnt  = exp_cnt;
        e.cnt4 = exp_cnt4;
        e.lost = lost;
        sb.push_back(e);
        tick();
        slip_req = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        valid = 1'b0; slip_req = 1'b0; rx_lock = 1'b0;
        tick();
        total++;
        if ({bus.o_slip_pulse, bus.o_slip_pos, bus.o_slip_cnt, bus.o_lock_lost, bus.o_timeout, bus.o_sync_valid} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got pulse=%b pos=%0d cnt=%0d lost=%b tmo=%b sv=%b want all 0",
                     bus.o_slip_pulse, bus.o_slip_pos, bus.o_slip_cnt, bus.o_lock_lost, bus.o_timeout, bus.o_sync_valid);
        end
        #2 rst_n = 1'b1;
        valid = 1'b1;
        #1;
        total++;
        if (bus.o_sync_valid !== 1'b1) begin
            bad++;
            $display("FAIL reset_sync_valid got=%b want=1", bus.o_sync_valid);
        end
    endtask

    task automatic test_slip_blank();
        apply_reset();
        valid = 1'b1;
        tick();
        slip(1'b0);
        for (int i = 0; i < 6; i++) begin
            total++;
            if (bus.o_sync_valid !== (i == 5)) begin
                bad++;
                $display("FAIL blank_window step=%0d got=%b want=%b", i, bus.o_sync_valid, (i == 5));
            end
            tick();
        end
    endtask

    task automatic test_wrap_sat();
        apply_reset();
        valid = 1'b1;
        tick();
        for (int i = 0; i < 66; i++) begin
            slip(1'b0);
            repeat (5) tick();
            if (i == 14 || i == 19) begin
                total++;
                if (bus4.o_slip_cnt !== 4'd15 || bus.o_slip_cnt !== 16'(i + 1)) begin
                    bad++;
                    $display("FAIL sat_cnt slips=%0d got cnt4=%0d cnt=%0d want cnt4=15 cnt=%0d",
                             i + 1, bus4.o_slip_cnt, bus.o_slip_cnt, i + 1);
                end
            end
        end
        total++;
        if (bus.o_slip_pos !== 7'd0 || bus.o_slip_cnt !== 16'd66 || bus4.o_slip_cnt !== 4'd15) begin
            bad++;
            $display("FAIL wrap got pos=%0d cnt=%0d cnt4=%0d want pos=0 cnt=66 cnt4=15",
                     bus.o_slip_pos, bus.o_slip_cnt, bus4.o_slip_cnt);
        end
    endtask

    task automatic test_lock();
        apply_reset();
        valid = 1'b1;
        tick();
        rx_lock = 1'b1;
        tick();
        total++;
        if (bus.o_sync_valid !== 1'b1 || bus.o_lock_lost !== 1'b0) begin
            bad++;
            $display("FAIL locked_enter got sv=%b lost=%b want sv=1 lost=0", bus.o_sync_valid, bus.o_lock_lost);
        end
        tick();
        rx_lock = 1'b0;
        tick();
        total++;
        if (bus.o_lock_lost !== 1'b1) begin
            bad++;
            $display("FAIL lock_drop got=%b want=1", bus.o_lock_lost);
        end
        tick();
        total++;
        if (bus.o_lock_lost !== 1'b0) begin
            bad++;
            $display("FAIL lock_drop_single got=%b want=0", bus.o_lock_lost);
        end
        rx_lock = 1'b1;
        tick();
        tick();
        slip(1'b1);
        repeat (5) tick();
        tick();
        rx_lock = 1'b0;
        tick();
        total++;
        if (bus.o_lock_lost !== 1'b1) begin
            bad++;
            $display("FAIL relock_drop got=%b want=1", bus.o_lock_lost);
        end
        repeat (2) tick();
    endtask

    task automatic test_ignored();
        apply_reset();
        valid = 1'b1;
        tick();
        slip(1'b0);
        slip_req = 1'b1;
        rx_lock  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (bus.o_sync_valid !== 1'b0) begin
                bad++;
                $display("FAIL ignored_mask step=%0d got=%b want=0", i, bus.o_sync_valid);
            end
            tick();
        end
        slip_req = 1'b0;
        rx_lock  = 1'b0;
        total++;
        if (bus.o_slip_pos !== 7'd1 || bus.o_slip_cnt !== 16'd1) begin
            bad++;
            $display("FAIL ignored_pos got pos=%0d cnt=%0d want pos=1 cnt=1", bus.o_slip_pos, bus.o_slip_cnt);
        end
        tick();
        rx_lock = 1'b1;
        slip(1'b0);
        rx_lock = 1'b0;
        repeat (6) tick();
    endtask

    task automatic test_timeout();
        logic exp;
        apply_reset();
        valid = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            exp = (i == 9 || i == 17 || i == 25);
            total++;
            if (bus.o_timeout !== exp) begin
                bad++;
                $display("FAIL timeout_free block=%0d got=%b want=%b", i, bus.o_timeout, exp);
            end
            tick();
        end
        apply_reset();
        valid = 1'b1;
        for (int i = 1; i <= 22; i++) begin
            rx_lock = (i >= 5 && i <= 10);
            #1;
            exp = (i == 20);
            total++;
            if (bus.o_timeout !== exp || bus.o_lock_lost !== (i == 12)) begin
                bad++;
                $display("FAIL timeout_relock block=%0d got tmo=%b lost=%b want tmo=%b lost=%b",
                         i, bus.o_timeout, bus.o_lock_lost, exp, (i == 12));
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        valid = 1'b1;
        tick();
        slip(1'b0);
        #1 rst_n = 1'b0;
        sb.delete();
        exp_pos = '0; exp_cnt = '0; exp_cnt4 = '0;
        #1;
        total++;
        if (bus.o_slip_pulse !== 1'b0 || bus.o_sync_valid !== 1'b1) begin
            bad++;
            $display("FAIL async_mid_slip got pulse=%b sv=%b want pulse=0 sv=1", bus.o_slip_pulse, bus.o_sync_valid);
        end
        tick();
        #2 rst_n = 1'b1;
        tick();
        slip(1'b0);
        tick();
        tick();
        #2 rst_n = 1'b0;
        sb.delete();
        exp_pos = '0; exp_cnt = '0; exp_cnt4 = '0;
        #1;
        total++;
        if ({bus.o_slip_pulse, bus.o_slip_pos, bus.o_slip_cnt, bus.o_lock_lost, bus.o_timeout, bus4.o_slip_cnt} !== '0
            || bus.o_sync_valid !== 1'b1) begin
            bad++;
            $display("FAIL async_mid_blank got pulse=%b pos=%0d cnt=%0d lost=%b tmo=%b cnt4=%0d sv=%b want zeros sv=1",
                     bus.o_slip_pulse, bus.o_slip_pos, bus.o_slip_cnt, bus.o_lock_lost, bus.o_timeout,
                     bus4.o_slip_cnt, bus.o_sync_valid);
        end
        valid = 1'b0;
        tick();
        #2 rst_n = 1'b1;
        #1;
        total++;
        if (bus.o_sync_valid !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_sv_low got=%b want=0", bus.o_sync_valid);
        end
        valid = 1'b1;
        #1;
        total++;
        if (bus.o_sync_valid !== 1'b1) begin
            bad++;
            $display("FAIL post_reset_sv_high got=%b want=1", bus.o_sync_valid);
        end
        repeat (10) tick();
        total++;
        if (bus.o_slip_pos !== 7'd0 || bus.o_slip_cnt !== 16'd0) begin
            bad++;
            $display("FAIL post_reset_quiet got pos=%0d cnt=%0d want pos=0 cnt=0", bus.o_slip_pos, bus.o_slip_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_slip_blank();
        test_wrap_sat();
        test_lock();
        test_ignored();
        test_timeout();
        test_async_reset();
        tick();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
